// File: rtl/perex_pma_tx_if.sv
// PCS-side handshake for the transmit PMA gearbox: 20-bit code-group pairs over valid/ready.
interface perex_pma_tx_if;
  logic [19:0] pcs_tx_data;
  logic        pcs_tx_valid;
  logic        pcs_tx_ready;

  modport master (output pcs_tx_data, output pcs_tx_valid, input pcs_tx_ready);
  modport slave (input pcs_tx_data, input pcs_tx_valid, output pcs_tx_ready);
endinterface

// File: rtl/perex_pma_tx.sv
// Transmit PMA gearbox: 20-bit pairs in, one 10-bit code group per clock out, low half first.
// Pairs are never split; an empty FIFO is covered with idle fill pairs.
module perex_pma_tx #(
  parameter logic [9:0]  IDLE_LO = 10'b0011111010,
  parameter logic [9:0]  IDLE_HI = 10'b1001000101,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             tx_clk,
  input  logic             tx_rst_n,
  input  logic             tx_enable,
  input  logic             bit_reverse,
  perex_pma_tx_if.slave    pcs,
  output logic [9:0]       pma_tx_data,
  output logic             pma_tx_even,
  output logic             tx_idle_fill,
  output logic             tx_underrun,
  output logic [CNT_W-1:0] underrun_count
);

  // StLead is the mandatory first fill pair after leaving OFF.
  typedef enum logic [1:0] {StOff, StLead, StIdle, StData} state_e;

  state_e state_q, state_d;
  logic   odd_q, odd_d;

  logic [19:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop, flush;

  logic        sel_fill, start_ur;
  logic [19:0] pair;
  logic [9:0]  hold_q, hold_d;
  logic        hold_rev_q, hold_rev_d, hold_fill_q, hold_fill_d;

  logic [9:0]       data_q, data_d;
  logic             even_q, even_d, fill_q, fill_d, ur_q, ur_d;
  logic [CNT_W-1:0] ucnt_q, ucnt_d;

  function automatic logic [9:0] rev10(input logic [9:0] v, input logic en);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return en ? r : v;
  endfunction

  assign pcs.pcs_tx_ready = (cnt_q != 2'd2) && (state_q != StOff);
  assign push             = pcs.pcs_tx_valid && pcs.pcs_tx_ready;
  assign flush            = (state_d == StOff);
  assign cnt_d            = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= pcs.pcs_tx_data;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q <= StOff;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      odd_q   <= odd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!odd_q) begin
      unique case (state_q)
        StOff:          if (tx_enable) state_d = StLead;
        StLead:         state_d = tx_enable ? StIdle : StOff;
        StIdle, StData: begin
          if (!tx_enable)        state_d = StOff;
          else if (cnt_q != '0) state_d = StData;
          else                   state_d = StIdle;
        end
        default:        state_d = StOff;
      endcase
    end
    // OFF parks the phase on even so the first pair after enable lands in an even slot.
    odd_d = (state_q == StOff || state_d == StOff) ? 1'b0 : ~odd_q;
  end

  always_comb begin
    pop      = 1'b0;
    sel_fill = 1'b0;
    start_ur = 1'b0;
    if (!odd_q && tx_enable) begin
      case (state_q)
        StLead:         sel_fill = 1'b1;
        StIdle, StData: begin
          if (cnt_q != '0) begin
            pop = 1'b1;
          end else begin
            sel_fill = 1'b1;
            start_ur = (state_q == StData);
          end
        end
        default: ;
      endcase
    end
    pair = sel_fill ? {IDLE_HI, IDLE_LO} : mem_q[rd_ptr_q];

    hold_d      = hold_q;
    hold_rev_d  = hold_rev_q;
    hold_fill_d = hold_fill_q;
    data_d      = '0;
    even_d      = 1'b0;
    fill_d      = 1'b0;
    ur_d        = start_ur;
    if (odd_q) begin
      data_d = rev10(hold_q, hold_rev_q);
      fill_d = hold_fill_q;
    end else if (state_q != StOff && tx_enable) begin
      hold_d      = pair[19:10];
      hold_rev_d  = bit_reverse;
      hold_fill_d = sel_fill;
      data_d      = rev10(pair[9:0], bit_reverse);
      even_d      = 1'b1;
      fill_d      = sel_fill;
    end

    ucnt_d = ucnt_q;
    if (start_ur && ucnt_q != {CNT_W{1'b1}}) ucnt_d = ucnt_q + CNT_W'(1);
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      hold_q      <= '0;
      hold_rev_q  <= 1'b0;
      hold_fill_q <= 1'b0;
      data_q      <= '0;
      even_q      <= 1'b0;
      fill_q      <= 1'b0;
      ur_q        <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_rev_q  <= hold_rev_d;
      hold_fill_q <= hold_fill_d;
      data_q      <= data_d;
      even_q      <= even_d;
      fill_q      <= fill_d;
      ur_q        <= ur_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign pma_tx_data    = data_q;
  assign pma_tx_even    = even_q;
  assign tx_idle_fill   = fill_q;
  assign tx_underrun    = ur_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_perex_pma_tx.sv
// Bench for perex_pma_tx: vector table, directed corner sequences, and a random run
// against a pair-level reference model.
module tb_perex_pma_tx;
  localparam logic [9:0] IDLE_LO = 10'b0011111010;
  localparam logic [9:0] IDLE_HI = 10'b1001000101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        br = 1'b0;
  logic [9:0]  data;
  logic        even, fill, ur;
  logic [15:0] ucnt;

  perex_pma_tx_if bus ();

  perex_pma_tx dut (
    .tx_clk        (clk),
    .tx_rst_n      (rst_n),
    .tx_enable     (en),
    .bit_reverse   (br),
    .pcs           (bus),
    .pma_tx_data   (data),
    .pma_tx_even   (even),
    .tx_idle_fill  (fill),
    .tx_underrun   (ur),
    .underrun_count(ucnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [9:0] d, input logic e, input logic f,
                         input logic u);
    chk(name, 32'({data, even, fill, ur}), 32'({d, e, f, u}));
  endtask

  task automatic drive(input logic e, input logic b, input logic v, input logic [19:0] d);
    en = e;
    br = b;
    bus.pcs_tx_valid = v;
    bus.pcs_tx_data  = d;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 20'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] flip(input logic [9:0] v, input logic b);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return b ? r : v;
  endfunction

  typedef struct {
    logic        en, br, vld;
    logic [19:0] dat;
    logic        rdy;
    logic [9:0]  od;
    logic        oe, of, ou;
  } vec_t;

  vec_t tbl [15];

  typedef enum int {MOff, MLead, MIdle, MData} mmode_e;

  initial begin
    // Inputs for one cycle; ready expected in that cycle; outputs expected the cycle after.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 20'h00001, 1'b1, IDLE_LO, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 20'h00401, 1'b1, IDLE_HI, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 20'h00000, 1'b0, 10'h200, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h001, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 20'h00000, 1'b1, 10'h001, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, IDLE_LO, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 20'h12345, 1'b1, IDLE_HI, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 20'h6789A, 1'b1, 10'h345, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h048, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h09A, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h19E, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 20'h00000, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};

    // ---- reset state and vector table ----
    reset_dut();
    chk_out("reset outputs", 10'h000, 1'b0, 1'b0, 1'b0);
    chk("reset ready", 32'(bus.pcs_tx_ready), 32'd0);
    chk("reset count", 32'(ucnt), 32'd0);
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].en, tbl[i].br, tbl[i].vld, tbl[i].dat);
      chk($sformatf("vec%0d ready", i), 32'(bus.pcs_tx_ready), 32'(tbl[i].rdy));
      tick();
      chk_out($sformatf("vec%0d out", i), tbl[i].od, tbl[i].oe, tbl[i].of, tbl[i].ou);
    end
    chk("vec underrun count", 32'(ucnt), 32'd1);

    // ---- disable drops queued pairs; re-enable starts with a fill pair ----
    begin
      logic [19:0] c;
      c = 20'h3C0F1;
      drive(1'b1, 1'b0, 1'b0, 20'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 20'hAAAAA);
      tick();
      chk_out("flush lead lo", IDLE_LO, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 20'h55555);
      tick();
      chk_out("flush lead hi", IDLE_HI, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 20'h0);
      tick();
      chk_out("flush off", 10'h000, 1'b0, 1'b0, 1'b0);
      chk("flush off ready", 32'(bus.pcs_tx_ready), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 20'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, c);
      tick();
      chk_out("reenable lo", IDLE_LO, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 20'h0);
      tick();
      chk_out("reenable hi", IDLE_HI, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("reenable new lo", c[9:0], 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("reenable new hi", c[19:10], 1'b0, 1'b0, 1'b0);
    end

    // ---- reset mid-pair with the FIFO full ----
    reset_dut();
    drive(1'b1, 1'b0, 1'b0, 20'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 20'h11111);
    tick();
    drive(1'b1, 1'b0, 1'b1, 20'h22222);
    tick();
    chk("full ready", 32'(bus.pcs_tx_ready), 32'd0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 20'h0);
    tick();
    chk_out("midreset outputs", 10'h000, 1'b0, 1'b0, 1'b0);
    chk("midreset ready", 32'(bus.pcs_tx_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("postreset off", 10'h000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("postreset lo", IDLE_LO, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("postreset hi", IDLE_HI, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("postreset fifo empty", IDLE_LO, 1'b1, 1'b1, 1'b0);

    // ---- sustained stream of 10 pairs, then valid drops ----
    begin
      logic [19:0] exp_q [$];
      logic [19:0] p;
      logic [9:0]  pend_hi;
      logic        want_hi, acc, tail_seen;
      int          sent, ndata, nlead, nmid, nur;
      sent = 0; ndata = 0; nlead = 0; nmid = 0; nur = 0;
      want_hi = 1'b0; tail_seen = 1'b0;
      reset_dut();
      for (int c = 0; c < 60; c++) begin
        drive(1'b1, 1'b0, sent < 10, 20'h12345 + 20'(sent));
        acc = bus.pcs_tx_valid && bus.pcs_tx_ready;
        p   = bus.pcs_tx_data;
        tick();
        if (acc) begin
          exp_q.push_back(p);
          sent++;
        end
        if (want_hi) begin
          chk("stream hi", 32'(data), 32'(pend_hi));
          want_hi = 1'b0;
        end else if (even && !fill) begin
          chk("stream pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            chk("stream lo", 32'(data), 32'(p[9:0]));
            pend_hi = p[19:10];
            want_hi = 1'b1;
            ndata++;
          end
        end
        if (even && fill && ndata == 0) nlead++;
        if (even && fill && ndata > 0 && ndata < 10) nmid++;
        if (even && fill && ndata == 10 && !tail_seen) begin
          chk("stream tail underrun", 32'(ur), 32'd1);
          tail_seen = 1'b1;
        end
        if (ur) nur++;
      end
      chk("stream pairs", 32'(ndata), 32'd10);
      chk("stream lead fills", 32'(nlead), 32'd1);
      chk("stream mid fills", 32'(nmid), 32'd0);
      chk("stream underruns", 32'(nur), 32'd1);
      chk("stream count", 32'(ucnt), 32'd1);
    end

    // ---- random traffic against a pair-level model ----
    begin
      mmode_e      mode;
      logic [19:0] q [$];
      logic [19:0] pr;
      logic [9:0]  hi_half, e_d;
      logic        odd_slot, hi_rev, hi_fill, e_e, e_f, e_u, m_rdy, is_fill;
      int          e_cnt, thr;
      reset_dut();
      mode = MOff; odd_slot = 1'b0; e_cnt = 0; thr = 3;
      hi_half = '0; hi_rev = 1'b0; hi_fill = 1'b0;
      en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if (c % 200 == 0) thr = $urandom_range(1, 4);
        if (en) en = ($urandom_range(0, 79) != 0);
        else    en = ($urandom_range(0, 3) == 0);
        br = 1'($urandom_range(0, 1));
        bus.pcs_tx_valid = ($urandom_range(0, 3) < thr);
        bus.pcs_tx_data  = 20'($urandom);
        m_rdy = (mode != MOff) && (q.size() < 2);
        chk("rand ready", 32'(bus.pcs_tx_ready), 32'(m_rdy));

        e_d = '0; e_e = 1'b0; e_f = 1'b0; e_u = 1'b0;
        if (odd_slot) begin
          e_d = flip(hi_half, hi_rev);
          e_f = hi_fill;
          odd_slot = 1'b0;
        end else if (mode == MOff) begin
          if (en) mode = MLead;
        end else if (!en) begin
          mode = MOff;
        end else begin
          is_fill = 1'b1;
          pr = {IDLE_HI, IDLE_LO};
          if (mode == MLead) begin
            mode = MIdle;
          end else if (q.size() > 0) begin
            pr = q.pop_front();
            is_fill = 1'b0;
            mode = MData;
          end else begin
            e_u = (mode == MData);
            mode = MIdle;
          end
          e_d = flip(pr[9:0], br);
          e_e = 1'b1;
          e_f = is_fill;
          hi_half = pr[19:10];
          hi_rev = br;
          hi_fill = is_fill;
          odd_slot = 1'b1;
        end
        if (mode == MOff) q.delete();
        else if (bus.pcs_tx_valid && m_rdy) q.push_back(bus.pcs_tx_data);
        if (e_u) e_cnt++;

        tick();
        chk("rand out", 32'({data, even, fill, ur}), 32'({e_d, e_e, e_f, e_u}));
        chk("rand count", 32'(ucnt), 32'(e_cnt));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
